// File: rtl/uart_scan_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_scan_bridge_if
//   Byte-stream link between the UART wrapper and the scan bridge.
//   rx_* carries bytes from the UART receiver into the bridge, and tx_* carries
//   bytes from the bridge to the UART transmitter. Both use ready/valid, and a
//   transfer happens on a clock edge where valid and ready are both high.
//
//   Modports:
//     master : the UART wrapper side (drives rx_data/rx_valid and tx_ready)
//     slave  : the bridge side (drives rx_ready, tx_data and tx_valid)
// ---------------------------------------------------------------------------
interface uart_scan_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/uart_scan_bridge.sv
// ---------------------------------------------------------------------------
// uart_scan_bridge
//   Byte-level command engine behind the scan-chain UART. It decodes host
//   commands arriving on the receive stream and bit-bangs the scan chain. It
//   returns captured chain data and acknowledgements on the transmit stream.
//
//   Commands:
//     'S' (0x53) LEN d0..dLEN-1 : shift each data byte MSB first and return the
//                                 byte captured from scan_out after each one.
//                                 Send 'K' when done.
//     'U' (0x55)                : pulse scan_update for SCAN_CLK_DIV cycles,
//                                 then send 'K'.
//     'P' (0x50)                : echo 0x50.
//     other                     : send '?' (0x3F).
//
//   Ports:
//     clk, reset   : system clock and asynchronous active-high reset
//     uart         : rx/tx byte streams (slave side of uart_scan_bridge_if)
//     scan_clk     : chain shift clock, high only while in SHIFT_HI
//     scan_in      : serial data into the chain head
//     scan_enable  : chain is in shift mode (held high for a whole SHIFT frame)
//     scan_update  : latch chain contents into the shadow registers
//     scan_out     : serial data from the chain tail
//     busy         : bridge is not idle
//
//   All outputs are registered. The state-decoded flags are computed from the
//   next state, so each flag matches the current state without a decode glitch.
// ---------------------------------------------------------------------------
module uart_scan_bridge #(
  parameter int SCAN_CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_scan_bridge_if.slave uart,
  output logic              scan_clk,
  output logic              scan_in,
  output logic              scan_enable,
  output logic              scan_update,
  input  logic              scan_out,
  output logic              busy
);

  localparam int DIV_W = (SCAN_CLK_DIV > 1) ? $clog2(SCAN_CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_CLK_DIV - 1);

  localparam logic [7:0] CMD_SHIFT  = 8'h53;
  localparam logic [7:0] CMD_UPDATE = 8'h55;
  localparam logic [7:0] CMD_PING   = 8'h50;
  localparam logic [7:0] RSP_ACK    = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_LEN  = 3'd1,
    ST_GET_BYTE = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_SEND_CAP = 3'd5,
    ST_UPDATE   = 3'd6,
    ST_SEND_RSP = 3'd7
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [DIV_W-1:0]   div_cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         byte_cnt_r;
  logic [6:0]         shift_r;      // bits still to be driven onto scan_in
  logic [7:0]         cap_r;        // bits captured from scan_out, first one ends in the MSB
  logic [7:0]         tx_data_r;
  logic               scan_in_r;
  logic               scan_clk_r;
  logic               scan_enable_r;
  logic               scan_update_r;
  logic               tx_valid_r;
  logic               rx_ready_r;
  logic               busy_r;

  logic               rx_fire_s;
  logic               tx_fire_s;
  logic               div_last_s;
  logic               div_state_s;
  logic               len_load_s;
  logic               byte_load_s;
  logic               bit_next_s;
  logic               sample_s;
  logic               cap_load_s;
  logic               byte_dec_s;
  logic               rsp_load_s;
  logic [7:0]         rsp_data_s;

  assign rx_fire_s   = uart.rx_valid & rx_ready_r;
  assign tx_fire_s   = tx_valid_r & uart.tx_ready;
  assign div_last_s  = (div_cnt_r == DIV_LAST);
  assign div_state_s = (state_r == ST_SHIFT_LO) || (state_r == ST_SHIFT_HI) ||
                       (state_r == ST_UPDATE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and datapath load strobes
  always_comb begin
    state_next_s = state_r;
    len_load_s   = 1'b0;
    byte_load_s  = 1'b0;
    bit_next_s   = 1'b0;
    sample_s     = 1'b0;
    cap_load_s   = 1'b0;
    byte_dec_s   = 1'b0;
    rsp_load_s   = 1'b0;
    rsp_data_s   = 8'h00;

    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          case (uart.rx_data)
            CMD_SHIFT:  state_next_s = ST_GET_LEN;
            CMD_UPDATE: state_next_s = ST_UPDATE;
            CMD_PING: begin
              state_next_s = ST_SEND_RSP;
              rsp_load_s   = 1'b1;
              rsp_data_s   = CMD_PING;
            end
            default: begin
              state_next_s = ST_SEND_RSP;
              rsp_load_s   = 1'b1;
              rsp_data_s   = RSP_ERR;
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_GET_LEN: begin
        if (rx_fire_s) begin
          len_load_s = 1'b1;
          if (uart.rx_data == 8'h00) begin
            state_next_s = ST_SEND_RSP;
            rsp_load_s   = 1'b1;
            rsp_data_s   = RSP_ACK;
          end else begin
            state_next_s = ST_GET_BYTE;
          end
        end else begin
          state_next_s = ST_GET_LEN;
        end
      end

      ST_GET_BYTE: begin
        if (rx_fire_s) begin
          byte_load_s  = 1'b1;
          state_next_s = ST_SHIFT_LO;
        end else begin
          state_next_s = ST_GET_BYTE;
        end
      end

      // scan_out is sampled on the last low cycle, just before scan_clk rises
      ST_SHIFT_LO: begin
        if (div_last_s) begin
          sample_s     = 1'b1;
          state_next_s = ST_SHIFT_HI;
        end else begin
          state_next_s = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_HI: begin
        if (div_last_s) begin
          if (bit_cnt_r == 3'd0) begin
            cap_load_s   = 1'b1;
            state_next_s = ST_SEND_CAP;
          end else begin
            bit_next_s   = 1'b1;
            state_next_s = ST_SHIFT_LO;
          end
        end else begin
          state_next_s = ST_SHIFT_HI;
        end
      end

      ST_SEND_CAP: begin
        if (tx_fire_s) begin
          byte_dec_s = 1'b1;
          if (byte_cnt_r == 8'd1) begin
            state_next_s = ST_SEND_RSP;
            rsp_load_s   = 1'b1;
            rsp_data_s   = RSP_ACK;
          end else begin
            state_next_s = ST_GET_BYTE;
          end
        end else begin
          state_next_s = ST_SEND_CAP;
        end
      end

      ST_UPDATE: begin
        if (div_last_s) begin
          state_next_s = ST_SEND_RSP;
          rsp_load_s   = 1'b1;
          rsp_data_s   = RSP_ACK;
        end else begin
          state_next_s = ST_UPDATE;
        end
      end

      ST_SEND_RSP: begin
        if (tx_fire_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND_RSP;
        end
      end

      default: state_next_s = ST_IDLE;
    endcase
  end

  // Phase-length counter. It restarts on every state change and only runs in the timed states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (state_next_s != state_r) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (div_state_s) begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end else begin
      div_cnt_r <= {DIV_W{1'b0}};
    end
  end

  // Bit and byte counters for a SHIFT frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 8'd0;
    end else begin
      if (byte_load_s) begin
        bit_cnt_r <= 3'd7;
      end else if (bit_next_s) begin
        bit_cnt_r <= bit_cnt_r - 3'd1;
      end
      if (len_load_s) begin
        byte_cnt_r <= uart.rx_data;
      end else if (byte_dec_s) begin
        byte_cnt_r <= byte_cnt_r - 8'd1;
      end
    end
  end

  // Serial data path. The MSB goes out when the byte is accepted and later bits on each SHIFT_HI->SHIFT_LO step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_in_r <= 1'b0;
      shift_r   <= 7'd0;
      cap_r     <= 8'h00;
    end else begin
      if (byte_load_s) begin
        scan_in_r <= uart.rx_data[7];
        shift_r   <= uart.rx_data[6:0];
      end else if (bit_next_s) begin
        scan_in_r <= shift_r[6];
        shift_r   <= {shift_r[5:0], 1'b0};
      end
      if (sample_s) begin
        cap_r <= {cap_r[6:0], scan_out};
      end
    end
  end

  // Transmit byte. It only changes when the next state is loaded, so it holds steady through a tx stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_r <= 8'h00;
    end else if (rsp_load_s) begin
      tx_data_r <= rsp_data_s;
    end else if (cap_load_s) begin
      tx_data_r <= cap_r;
    end
  end

  // Registered state-decoded outputs, computed from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_clk_r    <= 1'b0;
      scan_enable_r <= 1'b0;
      scan_update_r <= 1'b0;
      tx_valid_r    <= 1'b0;
      rx_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      scan_clk_r    <= (state_next_s == ST_SHIFT_HI);
      scan_enable_r <= (state_next_s == ST_GET_BYTE) || (state_next_s == ST_SHIFT_LO) ||
                       (state_next_s == ST_SHIFT_HI) || (state_next_s == ST_SEND_CAP);
      scan_update_r <= (state_next_s == ST_UPDATE);
      tx_valid_r    <= (state_next_s == ST_SEND_CAP) || (state_next_s == ST_SEND_RSP);
      rx_ready_r    <= (state_next_s == ST_IDLE) || (state_next_s == ST_GET_LEN) ||
                       (state_next_s == ST_GET_BYTE);
      busy_r        <= (state_next_s != ST_IDLE);
    end
  end

  assign uart.rx_ready = rx_ready_r;
  assign uart.tx_valid = tx_valid_r;
  assign uart.tx_data  = tx_data_r;
  assign scan_clk      = scan_clk_r;
  assign scan_in       = scan_in_r;
  assign scan_enable   = scan_enable_r;
  assign scan_update   = scan_update_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_scan_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_scan_bridge
//   Directed bench for uart_scan_bridge with SCAN_CLK_DIV = 2. An 8-bit chain
//   model shifts scan_in on each scan_clk rise and drives scan_out from its MSB.
// ---------------------------------------------------------------------------
module tb_uart_scan_bridge;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic reset;
  logic scan_clk, scan_in, scan_enable, scan_update, scan_out, busy;

  uart_scan_bridge_if bus();

  uart_scan_bridge #(.SCAN_CLK_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .uart        (bus),
    .scan_clk    (scan_clk),
    .scan_in     (scan_in),
    .scan_enable (scan_enable),
    .scan_update (scan_update),
    .scan_out    (scan_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Chain model and pin monitor, sampled on the falling edge
  logic [7:0] chain_r;
  logic [7:0] chain_init;
  logic [7:0] bits_r;
  logic       mon_clear;
  logic       clk_d;
  logic       en_seen;
  logic       upd_clk_bad;
  int         rise_cnt, hi_len, hi_bad, upd_len;

  assign scan_out = chain_r[7];

  always @(negedge clk) begin
    if (mon_clear) begin
      chain_r     <= chain_init;
      bits_r      <= 8'h00;
      clk_d       <= 1'b0;
      en_seen     <= 1'b0;
      upd_clk_bad <= 1'b0;
      rise_cnt    <= 0;
      hi_len      <= 0;
      hi_bad      <= 0;
      upd_len     <= 0;
    end else begin
      clk_d <= scan_clk;
      if (scan_clk && !clk_d) begin
        rise_cnt <= rise_cnt + 1;
        bits_r   <= {bits_r[6:0], scan_in};
        chain_r  <= {chain_r[6:0], scan_in};
      end
      if (scan_clk) begin
        hi_len <= hi_len + 1;
      end else begin
        if (clk_d && hi_len != DIV) hi_bad <= hi_bad + 1;
        hi_len <= 0;
      end
      if (scan_update) upd_len <= upd_len + 1;
      if (scan_update && scan_clk) upd_clk_bad <= 1'b1;
      if (scan_enable) en_seen <= 1'b1;
    end
  end

  task automatic clear_mon(input logic [7:0] init);
    chain_init = init;
    mon_clear  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    mon_clear  = 1'b0;
  endtask

  // Offer one byte on rx and return just after the edge that accepts it
  task automatic rx_send(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_accept", {31'h0, (n < 500)}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Wait for tx_valid and check latency (in falling edges) and data. Stall for
  // the given number of cycles, then take the byte.
  task automatic tx_expect(input string tag, input logic [7:0] exp, input int lat, input int stall);
    int n;
    @(negedge clk);
    n = 1;
    while (!bus.tx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_data"}, {24'h0, bus.tx_data}, {24'h0, exp});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, {31'h0, bus.tx_valid}, 32'd1);
      check_eq({tag, "_stall_data"}, {24'h0, bus.tx_data}, {24'h0, exp});
    end
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check_eq({tag, "_txv"}, {31'h0, bus.tx_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"}, {31'h0, bus.rx_ready}, 32'd1);
    check_eq({tag, "_tx_valid"}, {31'h0, bus.tx_valid}, 32'd0);
    check_eq({tag, "_tx_data"}, {24'h0, bus.tx_data}, 32'h00);
    check_eq({tag, "_scan_clk"}, {31'h0, scan_clk}, 32'd0);
    check_eq({tag, "_scan_in"}, {31'h0, scan_in}, 32'd0);
    check_eq({tag, "_scan_en"}, {31'h0, scan_enable}, 32'd0);
    check_eq({tag, "_scan_upd"}, {31'h0, scan_update}, 32'd0);
    check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset        = 1'b1;
    mon_clear    = 1'b1;
    chain_init   = 8'h3C;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    clear_mon(8'h3C);

    // PING with a five-cycle tx stall
    rx_send(8'h50);
    tx_expect("ping", 8'h50, 1, 5);
    check_idle("ping_end");

    // SHIFT one byte 0xA5 through a chain preloaded with 0x3C
    clear_mon(8'h3C);
    rx_send(8'h53);
    rx_send(8'h01);
    rx_send(8'hA5);
    tx_expect("shift1_cap", 8'h3C, 1 + 16 * DIV, 0);
    tx_expect("shift1_ack", 8'h4B, 1, 0);
    check_idle("shift1_end");
    check_eq("shift1_rises", 32'(rise_cnt), 32'd8);
    check_eq("shift1_scan_in", {24'h0, bits_r}, 32'hA5);
    check_eq("shift1_hi_width", 32'(hi_bad), 32'd0);
    check_eq("shift1_chain", {24'h0, chain_r}, 32'hA5);
    check_eq("shift1_enable", {31'h0, en_seen}, 32'd1);
    check_eq("shift1_en_off", {31'h0, scan_enable}, 32'd0);

    // SHIFT two bytes: the second capture returns the first byte shifted in
    clear_mon(8'h3C);
    rx_send(8'h53);
    rx_send(8'h02);
    rx_send(8'hC3);
    tx_expect("shift2_cap0", 8'h3C, 1 + 16 * DIV, 3);
    rx_send(8'h0F);
    tx_expect("shift2_cap1", 8'hC3, 1 + 16 * DIV, 0);
    tx_expect("shift2_ack", 8'h4B, 1, 0);
    check_idle("shift2_end");
    check_eq("shift2_rises", 32'(rise_cnt), 32'd16);
    check_eq("shift2_chain", {24'h0, chain_r}, 32'h0F);
    check_eq("shift2_hi_width", 32'(hi_bad), 32'd0);

    // SHIFT with LEN = 0
    clear_mon(8'h3C);
    rx_send(8'h53);
    rx_send(8'h00);
    tx_expect("len0_ack", 8'h4B, 1, 0);
    check_idle("len0_end");
    check_eq("len0_rises", 32'(rise_cnt), 32'd0);
    check_eq("len0_enable", {31'h0, en_seen}, 32'd0);

    // UPDATE
    clear_mon(8'h3C);
    rx_send(8'h55);
    tx_expect("upd_ack", 8'h4B, 1 + DIV, 0);
    check_idle("upd_end");
    check_eq("upd_width", 32'(upd_len), 32'(DIV));
    check_eq("upd_rises", 32'(rise_cnt), 32'd0);
    check_eq("upd_clk_overlap", {31'h0, upd_clk_bad}, 32'd0);

    // Unknown command, then PING
    rx_send(8'h00);
    tx_expect("unk_rsp", 8'h3F, 1, 0);
    check_idle("unk_end");
    rx_send(8'h50);
    tx_expect("unk_ping", 8'h50, 1, 0);

    // Reset in the middle of a shift, after three bits
    clear_mon(8'h3C);
    rx_send(8'h53);
    rx_send(8'h01);
    rx_send(8'hA5);
    n = 0;
    while (rise_cnt < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_wait", {31'h0, (n < 500)}, 32'd1);
    check_eq("mid_busy", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rx_ready", {31'h0, bus.rx_ready}, 32'd1);
    check_eq("post_rst_txv", {31'h0, bus.tx_valid}, 32'd0);
    rx_send(8'h50);
    tx_expect("post_rst_ping", 8'h50, 1, 0);
    check_idle("post_rst_end");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
